rv16_writeback_unit: RTL
========================

Name: rv16_writeback_unit

Overview:
- Writeback stage of the rv16 core and the sole writer of the register file's rd_addr_in/rd_reg_in port.
- Merges in-order ALU results with out-of-order load returns that come through a small load-return queue.
- Drives one registered write per cycle.
- Publishes a pending-write mask so decode can stall on registers that have outstanding load writes.

Parameters:
- DATA, 16, datapath width.
- ADDR, 4, register address width (16 registers).
- DEPTH, 4, load-return queue entries; must be a power of 2, at least 2.

Ports:
- rv16_wb_clock  input  1  core clock; all state on the rising edge.
- rv16_wb_reset  input  1  asynchronous, active-high reset.
- alu_valid_in  input  1  ALU result valid this cycle; cannot be back-pressured.
- alu_rd_addr_in  input  ADDR  ALU destination register.
- alu_result_in  input  DATA  ALU result.
- mem_valid_in  input  1  load data valid.
- mem_ready_out  output  1  queue can accept a load this cycle.
- mem_rd_addr_in  input  ADDR  load destination register.
- mem_data_in  input  DATA  raw load data.
- mem_byte_in  input  1  1 = byte load (bits 7:0 only), 0 = word load.
- mem_sign_in  input  1  byte loads only: 1 = sign-extend from bit 7, 0 = zero-extend.
- rd_addr_out  output  ADDR  register file write address; 0 means no write.
- rd_reg_out  output  DATA  register file write data.
- pending_mask_out  output  2**ADDR  bit r set means a queued load targets register r.
- wb_overlap_err_out  output  1  sticky flag: an ALU write hit a pending register.

Behaviour:
- Reset (async, any time, including mid-drain):
  - rd_addr_out=0, rd_reg_out=0.
  - Queue emptied, all entries invalid; pending_mask_out=0; wb_overlap_err_out=0.
  - mem_ready_out=0 while reset is asserted, 1 in the first cycle after release.
- Idle output: the register file writes every cycle when its address is non-zero and forwards rd_reg_in to its reads. So whenever no write is issued, rd_addr_out=0 and rd_reg_out=0 (never stale data).
- Load accept:
  - A load is accepted when mem_valid_in && mem_ready_out.
  - mem_ready_out = !full, computed from registered count only; it has no combinational path from the valid inputs.
  - Data is extended at enqueue. Byte load: upper 8 bits = sign ? data[7] : 0. Word load: data unchanged.
  - Accepted loads with mem_rd_addr_in==0 are dropped. The handshake still completes and nothing is enqueued.
- Queue: circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. count has log2(DEPTH)+1 bits. Each entry holds {valid, addr, data}.
- Issue selection, once per cycle:
  - If alu_valid_in && alu_rd_addr_in!=0: next rd_addr_out/rd_reg_out = ALU. ALU has absolute priority.
  - Else if the queue head is valid: next output = head, head is popped.
  - Else if the queue is non-empty and the head is invalid (squashed): pop it and output idle.
  - Else output idle.
- Latency: exactly 1 cycle from ALU input to rd_*_out. For a load into an empty queue with no ALU traffic: 1 cycle from accept to rd_*_out, because an empty queue bypasses directly to the output register.
- Same-cycle enqueue and pop on a non-empty queue: count is unchanged and the pointers advance independently.
- WAW squash:
  - An ALU write to register r invalidates every queued entry with addr==r, since those are older loads.
  - A load to r accepted in the same cycle is not enqueued; the handshake still completes.
  - Any squash sets wb_overlap_err_out, which stays set until reset.
- pending_mask_out: OR over valid entries of a one-hot of addr. It is registered state only and does not include the current output register.
- Invariant: count never exceeds DEPTH. Invalid entries still occupy a slot until they are popped.

Decomposition:
- Package rv16_pkg holds:
  - DATA_W=16 and REG_ADDR_W=4.
  - typedef wb_entry_t {logic valid; logic [REG_ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}.
  - Function load_extend(data, byte, sign).
- One sub-module, rv16_wb_queue, owns the circular buffer with push/pop/squash-by-address, count, full/empty and the pending mask.
- The top level does extension, arbitration and the output register.

Test Plan:
- Reset mid-drain: 3 loads queued, assert rv16_wb_reset between clock edges → rd_addr_out=0, rd_reg_out=0 and pending_mask_out=0 immediately; mem_ready_out=1 in the cycle after release.
- Byte sign handling: load byte 0x00F3 to r5 with sign=1, then the same with sign=0 to r6 → r5 write 0xFFF3, r6 write 0x00F3. A word load 0x80F3 is unchanged.
- ALU priority: ALU writes r2..r7 for 6 consecutive cycles while 4 loads arrive → mem_ready_out=0 after the 4th accept. No ALU result is delayed; loads drain in order on the following 4 cycles. A 5th load waits and is accepted once a slot frees.
- WAW squash: load to r9 queued behind a full ALU burst, then ALU writes r9=0x1234 → the queued r9 entry never appears on rd_addr_out, pending bit 9 clears and wb_overlap_err_out=1.
- r0 handling: ALU rd=0 and load rd=0 → rd_addr_out stays 0, the queue does not grow, the handshake completes.
- Wrap-around: 3×DEPTH loads at one per cycle with no ALU traffic → outputs in exact acceptance order, one per cycle after the first, with pointers wrapping and no lost or duplicated entries.

Source files
------------

// File: rtl/rv16_pkg.sv
// Shared types and helpers for the rv16 writeback path.
// Holds the queue entry layout and load data extension.
package rv16_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] data,
        input logic              is_byte,
        input logic              sgn
    );
        if (is_byte)
            return {{(DATA_W-8){sgn & data[7]}}, data[7:0]};
        return data;
    endfunction

endpackage

// File: rtl/rv16_wb_queue.sv
// Load-return circular buffer with squash-by-address.
// Squashed entries keep their slot until popped.
module rv16_wb_queue
    import rv16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     rv16_wb_clock,
    input  logic                     rv16_wb_reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     squash,
    input  logic [REG_ADDR_W-1:0]    squash_addr,
    output wb_entry_t                head,
    output logic                     empty,
    output logic                     full,
    output logic [2**REG_ADDR_W-1:0] pending_mask
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    assign head  = slots[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    always_ff @(posedge rv16_wb_clock or posedge rv16_wb_reset) begin
        if (rv16_wb_reset) begin
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < DEPTH; i++)
                    if (slots[i].valid && slots[i].addr == squash_addr)
                        slots[i].valid <= 1'b0;
            end
            if (pop) begin
                slots[rd_ptr].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slots[i].valid)
                pending_mask[slots[i].addr] = 1'b1;
    end

endmodule

// File: rtl/rv16_writeback_unit.sv
// rv16 writeback stage: merges ALU results and queued loads
// into one registered register-file write per cycle.
module rv16_writeback_unit
    import rv16_pkg::*;
#(
    parameter int DATA  = DATA_W,
    parameter int ADDR  = REG_ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic               rv16_wb_clock,
    input  logic               rv16_wb_reset,
    input  logic               alu_valid_in,
    input  logic [ADDR-1:0]    alu_rd_addr_in,
    input  logic [DATA-1:0]    alu_result_in,
    input  logic               mem_valid_in,
    output logic               mem_ready_out,
    input  logic [ADDR-1:0]    mem_rd_addr_in,
    input  logic [DATA-1:0]    mem_data_in,
    input  logic               mem_byte_in,
    input  logic               mem_sign_in,
    output logic [ADDR-1:0]    rd_addr_out,
    output logic [DATA-1:0]    rd_reg_out,
    output logic [2**ADDR-1:0] pending_mask_out,
    output logic               wb_overlap_err_out
);

    logic            alu_wr;
    logic            mem_acc;
    logic            ld_hit;
    logic            ld_live;
    logic            bypass;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    wb_entry_t       q_head;
    wb_entry_t       ld_entry;
    logic [ADDR-1:0] nxt_addr;
    logic [DATA-1:0] nxt_data;
    logic            nxt_err;

    assign mem_ready_out = !rv16_wb_reset && !q_full;

    assign alu_wr  = alu_valid_in && (alu_rd_addr_in != '0);
    assign mem_acc = mem_valid_in && mem_ready_out;
    assign ld_hit  = alu_wr && (mem_rd_addr_in == alu_rd_addr_in);
    assign ld_live = mem_acc && (mem_rd_addr_in != '0) && !ld_hit;

    // An idle slot goes straight to the output register.
    assign bypass = ld_live && !alu_wr && q_empty;
    assign q_push = ld_live && !bypass;
    assign q_pop  = !alu_wr && !q_empty;

    assign ld_entry.valid = 1'b1;
    assign ld_entry.addr  = mem_rd_addr_in;
    assign ld_entry.data  = load_extend(mem_data_in, mem_byte_in, mem_sign_in);

    rv16_wb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .rv16_wb_clock(rv16_wb_clock),
        .rv16_wb_reset(rv16_wb_reset),
        .push         (q_push),
        .push_entry   (ld_entry),
        .pop          (q_pop),
        .squash       (alu_wr),
        .squash_addr  (alu_rd_addr_in),
        .head         (q_head),
        .empty        (q_empty),
        .full         (q_full),
        .pending_mask (pending_mask_out)
    );

    always_comb begin
        nxt_addr = '0;
        nxt_data = '0;
        if (alu_wr) begin
            nxt_addr = alu_rd_addr_in;
            nxt_data = alu_result_in;
        end else if (bypass) begin
            nxt_addr = ld_entry.addr;
            nxt_data = ld_entry.data;
        end else if (q_pop && q_head.valid) begin
            nxt_addr = q_head.addr;
            nxt_data = q_head.data;
        end
    end

    assign nxt_err = alu_wr && (pending_mask_out[alu_rd_addr_in]
                                || (mem_acc && ld_hit));

    always_ff @(posedge rv16_wb_clock or posedge rv16_wb_reset) begin
        if (rv16_wb_reset) begin
            rd_addr_out        <= '0;
            rd_reg_out         <= '0;
            wb_overlap_err_out <= 1'b0;
        end else begin
            rd_addr_out        <= nxt_addr;
            rd_reg_out         <= nxt_data;
            wb_overlap_err_out <= wb_overlap_err_out | nxt_err;
        end
    end

endmodule
